// File: rtl/rvv_decode_ctrl.sv
// Sequencing controller for the RVV decode unit: tracks issued uops of the head
// instruction, gates decoder pushes against Uops Queue space, and pops the Command Queue.
module rvv_decode_ctrl #(
  parameter int unsigned NUM_DE_UOP      = 4,
  parameter int unsigned UOP_INDEX_WIDTH = 3,
  parameter int unsigned UQ_FREE_WIDTH   = 4,
  parameter int unsigned STALL_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       insts_valid_cq2de,
  input  logic [UOP_INDEX_WIDTH:0]   uop_num,
  input  logic [NUM_DE_UOP-1:0]      uop_valid_de2uq,
  input  logic [UQ_FREE_WIDTH-1:0]   uq_free,
  input  logic                       flush,
  output logic [UOP_INDEX_WIDTH-1:0] uop_index_remain,
  output logic [NUM_DE_UOP-1:0]      push_de2uq,
  output logic                       pop_cq,
  output logic                       busy,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
  output logic                       err
);

  localparam int unsigned NUM_W    = UOP_INDEX_WIDTH + 1;
  localparam int unsigned CNT_W    = $clog2(NUM_DE_UOP + 1);
  localparam int unsigned W0       = (UQ_FREE_WIDTH > NUM_W) ? UQ_FREE_WIDTH : NUM_W;
  localparam int unsigned CW       = ((W0 > CNT_W) ? W0 : CNT_W) + 1;
  localparam int unsigned MAX_UOPS = 1 << UOP_INDEX_WIDTH;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;

  logic [0:0]                 state, state_nxt;
  logic [UOP_INDEX_WIDTH-1:0] idx_nxt;
  logic [STALL_CNT_WIDTH-1:0] stall_nxt;
  logic                       err_nxt;
  logic [CW-1:0]              v, num, cur, rem, n, sum;
  logic                       contig;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      uop_index_remain <= '0;
      stall_cnt        <= '0;
      err              <= 1'b0;
    end else begin
      state            <= state_nxt;
      uop_index_remain <= idx_nxt;
      stall_cnt        <= stall_nxt;
      err              <= err_nxt;
    end
  end

  assign busy = (state == SPLIT);

  // Acceptance count, push/pop generation and next-state logic
  always_comb begin
    v = '0;
    for (int unsigned i = 0; i < NUM_DE_UOP; i++) begin
      v = v + CW'(uop_valid_de2uq[i]);
    end
    num    = CW'(uop_num);
    cur    = CW'(uop_index_remain);
    rem    = (num > cur) ? (num - cur) : '0;
    contig = ((uop_valid_de2uq & (uop_valid_de2uq + NUM_DE_UOP'(1))) == '0);

    n = v;
    if (rem < n)              n = rem;
    if (CW'(uq_free) < n)     n = CW'(uq_free);
    if (CW'(NUM_DE_UOP) < n)  n = CW'(NUM_DE_UOP);
    if (!insts_valid_cq2de || flush) n = '0;

    sum    = cur + n;
    pop_cq = (n != '0) && (sum == num);
    for (int unsigned i = 0; i < NUM_DE_UOP; i++) begin
      push_de2uq[i] = (CW'(i) < n);
    end

    state_nxt = state;
    idx_nxt   = uop_index_remain;
    stall_nxt = stall_cnt;
    err_nxt   = err;

    if (flush) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      stall_nxt = '0;
    end else begin
      if (pop_cq)          idx_nxt = '0;
      else if (n != '0)    idx_nxt = UOP_INDEX_WIDTH'(sum);

      case (state)
        IDLE:    if (n != '0 && !pop_cq) state_nxt = SPLIT;
        SPLIT:   if (pop_cq)             state_nxt = IDLE;
        default:                         state_nxt = IDLE;
      endcase

      if (n != '0)
        stall_nxt = '0;
      else if (insts_valid_cq2de && v != '0 && stall_cnt != '1)
        stall_nxt = stall_cnt + STALL_CNT_WIDTH'(1);
    end

    // Protocol violations latch until reset; the dropped-valid check is waived on flush
    if ((state == SPLIT && !insts_valid_cq2de && !flush) ||
        (insts_valid_cq2de && (num == '0 || num > CW'(MAX_UOPS))) ||
        !contig ||
        (insts_valid_cq2de && v > rem))
      err_nxt = 1'b1;
  end

`ifdef ASSERT_ON
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!pop_cq || insts_valid_cq2de);
      assert (state != SPLIT || !insts_valid_cq2de || err ||
              CW'(uop_index_remain) < CW'(uop_num));
    end
  end
`endif

endmodule

// File: tb/tb_rvv_decode_ctrl.sv
// Scoreboard bench for rvv_decode_ctrl: a transaction-level model predicts each cycle's
// outputs into a queue, and a negedge monitor pops and compares them.
module tb_rvv_decode_ctrl;

  typedef struct packed {
    logic [3:0] push;
    logic       pop;
    logic [2:0] idx;
    logic       busy;
    logic [7:0] stall;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       insts_valid_cq2de;
  logic [3:0] uop_num;
  logic [3:0] uop_valid_de2uq;
  logic [3:0] uq_free;
  logic       flush;
  logic [2:0] uop_index_remain;
  logic [3:0] push_de2uq;
  logic       pop_cq;
  logic       busy;
  logic [7:0] stall_cnt;
  logic       err;

  rvv_decode_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .insts_valid_cq2de (insts_valid_cq2de),
    .uop_num           (uop_num),
    .uop_valid_de2uq   (uop_valid_de2uq),
    .uq_free           (uq_free),
    .flush             (flush),
    .uop_index_remain  (uop_index_remain),
    .push_de2uq        (push_de2uq),
    .pop_cq            (pop_cq),
    .busy              (busy),
    .stall_cnt         (stall_cnt),
    .err               (err)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_on = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: progress of the head instruction in plain integers
  int   m_idx = 0;
  bit   m_busy = 1'b0;
  int   m_stall = 0;
  bit   m_err = 1'b0;
  bit   m_done = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("push_de2uq",       int'(push_de2uq),       int'(mon_e.push));
        chk("pop_cq",           int'(pop_cq),           int'(mon_e.pop));
        chk("uop_index_remain", int'(uop_index_remain), int'(mon_e.idx));
        chk("busy",             int'(busy),             int'(mon_e.busy));
        chk("stall_cnt",        int'(stall_cnt),        int'(mon_e.stall));
        chk("err",              int'(err),              int'(mon_e.err));
      end
    end
  end

  task automatic drive(input bit valid, input int num, input logic [3:0] uv,
                       input int free, input bit fl);
    int   v, rem, n;
    bit   seen0, noncontig;
    exp_t e;
    insts_valid_cq2de = valid;
    uop_num           = 4'(num);
    uop_valid_de2uq   = uv;
    uq_free           = 4'(free);
    flush             = fl;

    v   = $countones(uv);
    rem = num - m_idx;
    if (rem < 0) rem = 0;
    n = v;
    if (rem < n)  n = rem;
    if (free < n) n = free;
    if (4 < n)    n = 4;
    if (!valid || fl) n = 0;

    e.push  = 4'((1 << n) - 1);
    e.pop   = (n > 0) && (m_idx + n == num);
    e.idx   = 3'(m_idx);
    e.busy  = m_busy;
    e.stall = 8'(m_stall);
    e.err   = m_err;
    exp_q.push_back(e);

    seen0 = 1'b0;
    noncontig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!uv[i]) seen0 = 1'b1;
      else if (seen0) noncontig = 1'b1;
    end
    if ((m_busy && !valid && !fl) || (valid && (num == 0 || num > 8)) ||
        noncontig || (valid && v > rem))
      m_err = 1'b1;

    m_done = e.pop || fl;
    if (fl) begin
      m_idx = 0; m_busy = 1'b0; m_stall = 0;
    end else begin
      if (e.pop) begin
        m_idx = 0; m_busy = 1'b0;
      end else if (n > 0) begin
        m_idx = (m_idx + n) % 8; m_busy = 1'b1;
      end
      if (n > 0) m_stall = 0;
      else if (valid && v > 0 && m_stall < 255) m_stall++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    exp_t e;
    insts_valid_cq2de = 1'b0;
    uop_num = '0;
    uop_valid_de2uq = '0;
    uq_free = '0;
    flush = 1'b0;
    rst_n = 1'b0;
    m_idx = 0; m_busy = 1'b0; m_stall = 0; m_err = 1'b0;
    e = '0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int num, rmn, vv, fr, gap;
    rst_n = 1'b0;
    insts_valid_cq2de = 1'b0;
    uop_num = '0;
    uop_valid_de2uq = '0;
    uq_free = '0;
    flush = 1'b0;
    @(posedge clk); #1;
    mon_on = 1'b1;
    do_reset();

    // Single-uop instruction
    drive(1, 1, 4'b0001, 8, 0);
    // LMUL=8 split in two cycles
    drive(1, 8, 4'b1111, 8, 0);
    drive(1, 8, 4'b1111, 8, 0);
    // Backpressure: two slots at a time, then the tail
    repeat (3) drive(1, 8, 4'b1111, 2, 0);
    drive(1, 8, 4'b0011, 8, 0);
    // Zero-space stall then release
    repeat (5) drive(1, 8, 4'b1111, 0, 0);
    drive(1, 8, 4'b1111, 4, 0);
    drive(1, 8, 4'b1111, 4, 0);
    // Flush mid-SPLIT
    drive(1, 8, 4'b1111, 8, 0);
    drive(1, 8, 4'b1111, 8, 1);
    drive(0, 0, 4'b0000, 8, 0);
    // Stall counter saturation
    repeat (300) drive(1, 8, 4'b1111, 0, 0);
    drive(1, 8, 4'b1111, 4, 0);
    drive(1, 8, 4'b1111, 4, 0);
    // Asynchronous reset mid-SPLIT
    drive(1, 8, 4'b1111, 8, 0);
    do_reset();

    // Randomized legal traffic with occasional flushes and idle gaps
    for (int t = 0; t < 300; t++) begin
      num = int'($urandom_range(1, 8));
      for (int c = 0; c < 100; c++) begin
        rmn = num - m_idx;
        vv  = (rmn < 4) ? rmn : 4;
        if ($urandom_range(0, 3) == 0) vv = int'($urandom_range(1, vv));
        fr  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
        drive(1, num, 4'((1 << vv) - 1), fr, ($urandom_range(0, 29) == 0));
        if (m_done) break;
      end
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) drive(0, 0, 4'b0000, int'($urandom_range(0, 15)), 0);
    end

    // Protocol errors, each followed by reset
    drive(1, 8, 4'b1111, 8, 0);
    drive(0, 0, 4'b0000, 8, 0);
    repeat (3) drive(0, 0, 4'b0000, 8, 0);
    do_reset();
    drive(1, 4, 4'b0101, 8, 0);
    drive(1, 4, 4'b0011, 8, 0);
    do_reset();
    drive(1, 0, 4'b0001, 8, 0);
    drive(0, 0, 4'b0000, 8, 0);
    do_reset();
    drive(1, 9, 4'b1111, 8, 0);
    drive(1, 9, 4'b1111, 8, 1);
    do_reset();
    drive(1, 2, 4'b0111, 8, 0);
    drive(0, 0, 4'b0000, 8, 0);
    do_reset();
    drive(0, 0, 4'b0000, 8, 0);

    mon_on = 1'b0;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
